alu_muldiv_seq: RTL and testbench

- Iterative MULT/MULTU/DIV/DIVU sequencer for the MIPS core; writes the 64-bit HI/LO result pair.
- Acts as the initiator on the ALU control interface: it drives ALU operands and control codes, and consumes the ALU result each cycle.
- Uses the external 32-bit ALU as its add/subtract datapath for 32 iterations, then presents HI/LO with a one-cycle done pulse.

---
 rtl/alu_muldiv_seq.sv | 261 ++++++++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer for the MIPS core.
//
// Drives an external 32-bit ALU as its add/subtract datapath for 32 iterations
// (shift-add multiply, restoring divide) and presents the 64-bit HI/LO pair with
// a one-cycle done pulse.
//
// Build option:
//   ALU_MULDIV_SIGNED_EN  defined   -> signed MULT/DIV (ops 10/11) via magnitude
//                                      iteration plus a one-cycle sign fix-up.
//                         undefined -> ops 10/11 are rejected with o_err.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_start, i_op       request strobe and op (00 MULTU, 01 DIVU, 10 MULT, 11 DIV)
//   i_a, i_b            multiplicand/dividend, multiplier/divisor
//   o_alu_ctrl/a/b      ALU control code and operands (driven only in CALC)
//   o_alu_shamt         ALU shift amount, always 0
//   i_alu_result        combinational ALU result for the current operands
//   o_busy, o_done      busy in CALC/FIX, one-cycle completion pulse
//   o_hi, o_lo          HI (product upper / remainder), LO (product lower / quotient)
//   o_div_zero, o_err   last completed op divided by zero, last request was unsupported

module alu_muldiv_seq #(
    parameter logic [3:0]  ALU_ADD = 4'b1000,
    parameter logic [3:0]  ALU_SUB = 4'b1001,
    parameter int unsigned ITER    = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [3:0]  o_alu_ctrl,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [4:0]  o_alu_shamt,
    input  logic [31:0] i_alu_result,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div_zero,
    output logic        o_err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [4:0] LastIter = 5'(ITER - 1);

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] w_hi_q, w_hi_d;
    logic [31:0] w_lo_q, w_lo_d;
    logic [31:0] d_q, d_d;
    logic        is_div_q, is_div_d;
    logic        dz_pend_q, dz_pend_d;
    logic        bad_op_q, bad_op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        div_zero_q, div_zero_d;

`ifdef ALU_MULDIV_SIGNED_EN
    logic        is_signed_q, is_signed_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic [63:0] prod_neg;
`endif

    logic [31:0] a_load;
    logic [31:0] b_load;
    logic [31:0] rem_shift;
    logic        mul_carry;

    // Operand magnitudes; 0x80000000 negates to itself and is used as unsigned.
`ifdef ALU_MULDIV_SIGNED_EN
    assign a_load   = (i_op[1] && i_a[31]) ? (32'd0 - i_a) : i_a;
    assign b_load   = (i_op[1] && i_b[31]) ? (32'd0 - i_b) : i_b;
    assign prod_neg = 64'd0 - {w_hi_q, w_lo_q};
`else
    assign a_load = i_a;
    assign b_load = i_b;
`endif

    // Partial remainder shifted left by one, pulling in the next dividend bit.
    assign rem_shift = {w_hi_q[30:0], w_lo_q[31]};
    // Carry out of W_HI + addend, recovered from the 32-bit ALU sum.
    assign mul_carry = (i_alu_result < w_hi_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_hi_d     = w_hi_q;
        w_lo_d     = w_lo_q;
        d_d        = d_q;
        is_div_d   = is_div_q;
        dz_pend_d  = dz_pend_q;
        bad_op_d   = bad_op_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        err_d      = err_q;
        div_zero_d = div_zero_q;
`ifdef ALU_MULDIV_SIGNED_EN
        is_signed_d = is_signed_q;
        neg_a_d     = neg_a_q;
        neg_b_d     = neg_b_q;
`endif
        o_alu_ctrl = ALU_ADD;
        o_alu_a    = 32'd0;
        o_alu_b    = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    cnt_d     = 5'd0;
                    w_hi_d    = 32'd0;
                    w_lo_d    = a_load;
                    d_d       = b_load;
                    is_div_d  = i_op[0];
                    dz_pend_d = i_op[0] && (i_b == 32'd0);
`ifdef ALU_MULDIV_SIGNED_EN
                    is_signed_d = i_op[1];
                    neg_a_d     = i_op[1] && i_a[31];
                    neg_b_d     = i_op[1] && i_b[31];
                    bad_op_d    = 1'b0;
                    state_d     = StCalc;
`else
                    if (i_op[1]) begin
                        // Unsupported signed op: flag it immediately, skip the datapath.
                        bad_op_d = 1'b1;
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                        state_d  = StDone;
                    end else begin
                        bad_op_d = 1'b0;
                        state_d  = StCalc;
                    end
`endif
                end
            end

            StCalc: begin
                cnt_d = cnt_q + 5'd1;
                if (is_div_q) begin
                    o_alu_ctrl = ALU_SUB;
                    o_alu_a    = rem_shift;
                    o_alu_b    = d_q;
                    // W_HI[31] set means the 33-bit remainder already exceeds D.
                    if (w_hi_q[31] || (rem_shift >= d_q)) begin
                        w_hi_d = i_alu_result;
                        w_lo_d = {w_lo_q[30:0], 1'b1};
                    end else begin
                        w_hi_d = rem_shift;
                        w_lo_d = {w_lo_q[30:0], 1'b0};
                    end
                end else begin
                    o_alu_ctrl       = ALU_ADD;
                    o_alu_a          = w_hi_q;
                    o_alu_b          = w_lo_q[0] ? d_q : 32'd0;
                    {w_hi_d, w_lo_d} = {mul_carry, i_alu_result, w_lo_q[31:1]};
                end
                if (cnt_q == LastIter) begin
`ifdef ALU_MULDIV_SIGNED_EN
                    state_d = is_signed_q ? StFix : StDone;
`else
                    state_d = StDone;
`endif
                end
            end

            StFix: begin
`ifdef ALU_MULDIV_SIGNED_EN
                if (is_div_q) begin
                    if (neg_a_q ^ neg_b_q) begin
                        w_lo_d = 32'd0 - w_lo_q;
                    end
                    // Remainder follows the sign of the dividend.
                    if (neg_a_q) begin
                        w_hi_d = 32'd0 - w_hi_q;
                    end
                end else if (neg_a_q ^ neg_b_q) begin
                    {w_hi_d, w_lo_d} = prod_neg;
                end
`endif
                state_d = StDone;
            end

            StDone: begin
                state_d = StIdle;
                // Result and done pulse are registered on the edge leaving DONE, so
                // they appear together in the following IDLE cycle.
                if (!bad_op_q) begin
                    hi_d       = w_hi_q;
                    lo_d       = w_lo_q;
                    done_d     = 1'b1;
                    div_zero_d = dz_pend_q;
                    err_d      = 1'b0;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            cnt_q      <= 5'd0;
            w_hi_q     <= 32'd0;
            w_lo_q     <= 32'd0;
            d_q        <= 32'd0;
            is_div_q   <= 1'b0;
            dz_pend_q  <= 1'b0;
            bad_op_q   <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef ALU_MULDIV_SIGNED_EN
            is_signed_q <= 1'b0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            w_hi_q     <= w_hi_d;
            w_lo_q     <= w_lo_d;
            d_q        <= d_d;
            is_div_q   <= is_div_d;
            dz_pend_q  <= dz_pend_d;
            bad_op_q   <= bad_op_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            err_q      <= err_d;
            div_zero_q <= div_zero_d;
`ifdef ALU_MULDIV_SIGNED_EN
            is_signed_q <= is_signed_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
`endif
        end
    end

    assign o_alu_shamt = 5'd0;
    assign o_busy      = (state_q == StCalc) || (state_q == StFix);
    assign o_done      = done_q;
    assign o_hi        = hi_q;
    assign o_lo        = lo_q;
    assign o_div_zero  = div_zero_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a queue-based scoreboard. Tests push an
// expected {HI, LO, div_zero, err, completion cycle} before each request; a
// monitor pops and compares on every o_done. An adder/subtractor stands in for
// the core ALU.

module tb_alu_muldiv_seq;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [3:0]  o_alu_ctrl;
    logic [31:0] o_alu_a;
    logic [31:0] o_alu_b;
    logic [4:0]  o_alu_shamt;
    logic [31:0] i_alu_result;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_div_zero;
    logic        o_err;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    alu_muldiv_seq dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_op         (i_op),
        .i_a          (i_a),
        .i_b          (i_b),
        .o_alu_ctrl   (o_alu_ctrl),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .o_alu_shamt  (o_alu_shamt),
        .i_alu_result (i_alu_result),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_hi         (o_hi),
        .o_lo         (o_lo),
        .o_div_zero   (o_div_zero),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    // External ALU stand-in: subtract for 1001, add otherwise.
    assign i_alu_result = (o_alu_ctrl == 4'b1001) ? (o_alu_a - o_alu_b) : (o_alu_a + o_alu_b);

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Must be called in the same time step as the start_op it describes.
    task automatic expect_res(input string name, input logic [31:0] hi, input logic [31:0] lo,
                              input logic dz, input logic err, input int lat);
        exp_t e;
        e.name = name;
        e.hi   = hi;
        e.lo   = lo;
        e.dz   = dz;
        e.err  = err;
        e.due  = cyc + 1 + lat;
        sb.push_back(e);
    endtask

    // Drives one request; returns 1ns into the first cycle after the acceptance edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        i_op    = op;
        i_a     = a;
        i_b     = b;
        i_start = 1'b1;
        @(negedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(negedge i_clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL wait_done: pending %0d, want 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge i_clk) begin
        if (!i_rst && o_done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done at cycle %0d, want none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_hi"}, o_hi, e.hi);
                chk({e.name, "_lo"}, o_lo, e.lo);
                chk({e.name, "_dz"}, {31'd0, o_div_zero}, {31'd0, e.dz});
                chk({e.name, "_err"}, {31'd0, o_err}, {31'd0, e.err});
                chk({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_op    = 2'd0;
        i_a     = 32'd0;
        i_b     = 32'd0;
        repeat (3) @(negedge i_clk);
        #1;
        i_rst = 1'b0;

        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_hi", o_hi, 32'd0);
        chk("rst_lo", o_lo, 32'd0);
        chk("rst_dz", {31'd0, o_div_zero}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);

        // MULTU max x max, with ALU operand and busy-length checks.
        expect_res("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 33);
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mul_it1_ctrl", {28'd0, o_alu_ctrl}, 32'h8);
        chk("mul_it1_a", o_alu_a, 32'h0000_0000);
        chk("mul_it1_b", o_alu_b, 32'hFFFF_FFFF);
        chk("mul_shamt", {27'd0, o_alu_shamt}, 32'd0);
        busy_n = o_busy ? 1 : 0;
        @(negedge i_clk);
        #1;
        chk("mul_it2_a", o_alu_a, 32'h7FFF_FFFF);
        chk("mul_it2_b", o_alu_b, 32'hFFFF_FFFF);
        if (o_busy) busy_n++;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            #1;
            if (o_busy) busy_n++;
        end
        chk("mul_busy_cycles", 32'(busy_n), 32'd32);
        chk("idle_alu_ctrl", {28'd0, o_alu_ctrl}, 32'h8);
        chk("idle_alu_a", o_alu_a, 32'd0);
        chk("idle_alu_b", o_alu_b, 32'd0);
        wait_done();

        // DIVU 100/7 with a second request mid-operation that must be ignored.
        expect_res("divu_100_7", 32'd2, 32'd14, 1'b0, 1'b0, 33);
        start_op(2'b01, 32'd100, 32'd7);
        chk("div_it1_ctrl", {28'd0, o_alu_ctrl}, 32'h9);
        chk("div_it1_a", o_alu_a, 32'd0);
        chk("div_it1_b", o_alu_b, 32'd7);
        repeat (4) @(negedge i_clk);
        #1;
        start_op(2'b00, 32'd9, 32'd9);
        wait_done();

        // Back-to-back requests issued in the done cycle.
        chk("b2b_done_cycle", {31'd0, o_done}, 32'd1);
        expect_res("divu_max_16", 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 1'b0, 33);
        start_op(2'b01, 32'hFFFF_FFFF, 32'd16);
        wait_done();
        expect_res("multu_max_2", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
        start_op(2'b00, 32'hFFFF_FFFF, 32'd2);
        wait_done();
        expect_res("divu_5_0", 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 33);
        start_op(2'b01, 32'd5, 32'd0);
        wait_done();

        // Reset at CALC cycle 10 abandons the op with no done pulse.
        start_op(2'b00, 32'd7, 32'd7);
        repeat (9) @(negedge i_clk);
        #1;
        i_rst = 1'b1;
        @(negedge i_clk);
        #1;
        i_rst = 1'b0;
        chk("midrst_busy", {31'd0, o_busy}, 32'd0);
        chk("midrst_done", {31'd0, o_done}, 32'd0);
        chk("midrst_hi", o_hi, 32'd0);
        chk("midrst_lo", o_lo, 32'd0);
        chk("midrst_dz", {31'd0, o_div_zero}, 32'd0);
        chk("midrst_err", {31'd0, o_err}, 32'd0);
        repeat (40) @(negedge i_clk);
        #1;
        expect_res("multu_3_4", 32'd0, 32'd12, 1'b0, 1'b0, 33);
        start_op(2'b00, 32'd3, 32'd4);
        wait_done();

`ifdef ALU_MULDIV_SIGNED_EN
        expect_res("mult_m3_5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0, 34);
        start_op(2'b10, 32'hFFFF_FFFD, 32'd5);
        wait_done();
        expect_res("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 34);
        start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done();
        expect_res("div_m7_0", 32'hFFFF_FFF9, 32'h0000_0001, 1'b1, 1'b0, 34);
        start_op(2'b11, 32'hFFFF_FFF9, 32'd0);
        wait_done();
        expect_res("mult_min_1", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 34);
        start_op(2'b10, 32'h8000_0000, 32'd1);
        wait_done();
`else
        // Unsupported signed op: immediate done with err, HI/LO untouched.
        expect_res("bad_op", 32'd0, 32'd12, 1'b0, 1'b1, 0);
        start_op(2'b10, 32'd1, 32'd1);
        chk("bad_op_busy", {31'd0, o_busy}, 32'd0);
        chk("bad_op_alu_a", o_alu_a, 32'd0);
        chk("bad_op_alu_b", o_alu_b, 32'd0);
        wait_done();
        @(negedge i_clk);
        #1;
        chk("bad_op_err_held", {31'd0, o_err}, 32'd1);
        chk("bad_op_done_once", {31'd0, o_done}, 32'd0);
        expect_res("multu_1_1", 32'd0, 32'd1, 1'b0, 1'b0, 33);
        start_op(2'b00, 32'd1, 32'd1);
        wait_done();
`endif

        repeat (3) @(negedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
